// File: rtl/fsqrt_arb_if.sv
// Request/response handshake bundle between FPU requesters and the fsqrt arbiter.
// Requester i uses bit i of each valid/ready vector and bits [32i+31:32i] of each data bus.
interface fsqrt_arb_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [32*N_REQ-1:0] rsp_y;
    logic [N_REQ-1:0]    rsp_ready;

    // Requester side: presents operands and consumes results.
    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_y
    );

    // Arbiter side: accepts operands and holds results.
    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/fsqrt_arb.sv
// Round-robin arbiter sharing one fully pipelined fsqrt unit among N_REQ requesters.
// A requester tag travels alongside each operand through a LAT-deep shadow pipe so the
// result can be steered back into that requester's result register. Each requester has
// at most one operation outstanding, which guarantees a free result register at capture.
module fsqrt_arb #(
    parameter int  N_REQ = 4,
    parameter int  LAT   = 2,
    localparam int TAG_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rstn,
    fsqrt_arb_if.slave       bus,
    output logic [31:0]      sq_x,
    input  logic [31:0]      sq_y,
    output logic [TAG_W:0]   inflight
);

    logic [N_REQ-1:0]    busy;
    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    req_ready_c;
    logic [N_REQ-1:0]    rsp_valid_q;
    logic [32*N_REQ-1:0] rsp_y_q;
    logic [TAG_W-1:0]    rr_ptr;
    logic                grant_vld;
    logic [TAG_W-1:0]    grant_id;
    logic [TAG_W-1:0]    idx;
    logic [LAT-1:0]      tag_vld;
    logic [TAG_W-1:0]    tag_id [LAT];
    logic                capture;
    logic [TAG_W-1:0]    cap_id;

    assign eligible      = bus.req_valid & ~busy;
    assign capture       = tag_vld[LAT-1];
    assign cap_id        = tag_id[LAT-1];
    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;

    // Round-robin search starting just after the last granted requester; nothing is granted during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = TAG_W'((int'(rr_ptr) + k) % N_REQ);
            if (rstn && !grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    // One-hot ready to the winner and its operand steered onto the shared fsqrt input.
    always_comb begin
        req_ready_c = '0;
        sq_x        = '0;
        if (grant_vld) begin
            req_ready_c[grant_id] = 1'b1;
            sq_x                  = bus.req_x[32*grant_id +: 32];
        end
    end

    // Round-robin pointer remembers the most recent winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= TAG_W'(N_REQ - 1);
        end else if (grant_vld) begin
            rr_ptr <= grant_id;
        end
    end

    // Shadow pipe carrying the requester tag in lockstep with the fsqrt datapath; it never stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= grant_vld;
            tag_id[0]  <= grant_id;
            for (int k = 1; k < LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Per-requester busy flag: set on grant, cleared when the result is handed over.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_vld && grant_id == TAG_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Result registers: load on capture for the tagged requester, drop valid on the response handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (capture && cap_id == TAG_W'(i)) begin
                    rsp_valid_q[i]       <= 1'b1;
                    rsp_y_q[32*i +: 32]  <= sq_y;
                end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Count of operations issued but not yet landed in a result register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= '0;
        end else if (grant_vld && !capture) begin
            inflight <= inflight + 1'b1;
        end else if (!grant_vld && capture) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule
